// File: rtl/core_ibex_rvfi_gen.sv
// core_ibex_rvfi_gen
// Producer end of the RVFI retirement channel. It captures the issue-time
// context of each instruction (PC, operands, privilege mode, sampled external
// state) in a small in-order FIFO. At retirement it merges the head entry with
// the writeback/memory results and emits one registered RVFI record, which
// carries a monotonically increasing order number.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   issue_*             issue record offered at ID; issue_ready is the accept
//   wb_*                retirement of the FIFO head plus its results
//   flush               discards all in-flight issue records
//   rvfi_*              one retirement record; rvfi_valid pulses once per record
//   pending             FIFO occupancy
//   err_retire_empty    sticky flag: a retirement arrived while the FIFO was empty
module core_ibex_rvfi_gen #(
    parameter int unsigned DEPTH       = 2,
    parameter logic [63:0] ORDER_RESET = 64'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [31:0]                issue_insn,
    input  logic [31:0]                issue_pc,
    input  logic [1:0]                 issue_mode,
    input  logic                       issue_intr,
    input  logic [4:0]                 issue_rs1_addr,
    input  logic [4:0]                 issue_rs2_addr,
    input  logic [31:0]                issue_rs1_rdata,
    input  logic [31:0]                issue_rs2_rdata,
    input  logic [31:0]                issue_ext_mip,
    input  logic                       issue_ext_nmi,
    input  logic [31:0]                issue_ext_debug_req,
    input  logic [63:0]                issue_ext_mcycle,
    input  logic                       wb_valid,
    input  logic                       wb_trap,
    input  logic                       wb_halt,
    input  logic [4:0]                 wb_rd_addr,
    input  logic [31:0]                wb_rd_wdata,
    input  logic [31:0]                wb_pc_wdata,
    input  logic [31:0]                wb_mem_addr,
    input  logic [31:0]                wb_mem_rdata,
    input  logic [31:0]                wb_mem_wdata,
    input  logic [3:0]                 wb_mem_rmask,
    input  logic [3:0]                 wb_mem_wmask,
    input  logic                       flush,
    output logic                       rvfi_valid,
    output logic [63:0]                rvfi_order,
    output logic [31:0]                rvfi_insn,
    output logic                       rvfi_trap,
    output logic                       rvfi_halt,
    output logic                       rvfi_intr,
    output logic [1:0]                 rvfi_mode,
    output logic [1:0]                 rvfi_ixl,
    output logic [4:0]                 rvfi_rs1_addr,
    output logic [4:0]                 rvfi_rs2_addr,
    output logic [31:0]                rvfi_rs1_rdata,
    output logic [31:0]                rvfi_rs2_rdata,
    output logic [4:0]                 rvfi_rd_addr,
    output logic [31:0]                rvfi_rd_wdata,
    output logic [31:0]                rvfi_pc_rdata,
    output logic [31:0]                rvfi_pc_wdata,
    output logic [31:0]                rvfi_mem_addr,
    output logic [3:0]                 rvfi_mem_rmask,
    output logic [3:0]                 rvfi_mem_wmask,
    output logic [31:0]                rvfi_mem_rdata,
    output logic [31:0]                rvfi_mem_wdata,
    output logic [31:0]                rvfi_ext_mip,
    output logic                       rvfi_ext_nmi,
    output logic [31:0]                rvfi_ext_debug_req,
    output logic [63:0]                rvfi_ext_mcycle,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       err_retire_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [1:0]  mode;
        logic        intr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] ext_mip;
        logic        ext_nmi;
        logic [31:0] ext_debug_req;
        logic [63:0] ext_mcycle;
    } issue_rec_t;

    issue_rec_t        fifo_q [DEPTH];
    issue_rec_t        push_rec;
    issue_rec_t        head;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [63:0]       order_q;
    logic              err_q;
    logic              push;
    logic              pop;

    // Retirement-side field qualification
    logic [4:0]        eff_rd_addr;
    logic [31:0]       eff_rd_wdata;
    logic [3:0]        eff_rmask;
    logic [3:0]        eff_wmask;

    assign rvfi_ixl         = 2'b01;
    assign pending          = count_q;
    assign err_retire_empty = err_q;

    // Readiness looks only at the start-of-cycle count, so a same-cycle
    // retirement never frees a slot for an issue while full.
    assign issue_ready = (count_q != CW'(DEPTH)) && !flush;
    assign push        = issue_valid && issue_ready;
    assign pop         = wb_valid && (count_q != '0);

    assign push_rec = '{
        insn:          issue_insn,
        pc:            issue_pc,
        mode:          issue_mode,
        intr:          issue_intr,
        rs1_addr:      issue_rs1_addr,
        rs2_addr:      issue_rs2_addr,
        rs1_rdata:     issue_rs1_rdata,
        rs2_rdata:     issue_rs2_rdata,
        ext_mip:       issue_ext_mip,
        ext_nmi:       issue_ext_nmi,
        ext_debug_req: issue_ext_debug_req,
        ext_mcycle:    issue_ext_mcycle
    };

    assign head = fifo_q[rd_ptr_q];

    // A trapped instruction commits neither a register nor a memory access,
    // and x0 never reports a written value.
    assign eff_rd_addr  = wb_trap ? 5'd0 : wb_rd_addr;
    assign eff_rd_wdata = (eff_rd_addr == 5'd0) ? 32'd0 : wb_rd_wdata;
    assign eff_rmask    = wb_trap ? 4'd0 : wb_mem_rmask;
    assign eff_wmask    = wb_trap ? 4'd0 : wb_mem_wmask;

    // Storage entries carry no reset; occupancy is tracked by count_q.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
                fifo_q[gi] <= push_rec;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            order_q  <= ORDER_RESET;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (pop) order_q <= order_q + 64'd1;
            if (wb_valid && (count_q == '0)) err_q <= 1'b1;
        end
    end

    // Record register: fields update only on retirement and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvfi_valid         <= 1'b0;
            rvfi_order         <= '0;
            rvfi_insn          <= '0;
            rvfi_trap          <= 1'b0;
            rvfi_halt          <= 1'b0;
            rvfi_intr          <= 1'b0;
            rvfi_mode          <= '0;
            rvfi_rs1_addr      <= '0;
            rvfi_rs2_addr      <= '0;
            rvfi_rs1_rdata     <= '0;
            rvfi_rs2_rdata     <= '0;
            rvfi_rd_addr       <= '0;
            rvfi_rd_wdata      <= '0;
            rvfi_pc_rdata      <= '0;
            rvfi_pc_wdata      <= '0;
            rvfi_mem_addr      <= '0;
            rvfi_mem_rmask     <= '0;
            rvfi_mem_wmask     <= '0;
            rvfi_mem_rdata     <= '0;
            rvfi_mem_wdata     <= '0;
            rvfi_ext_mip       <= '0;
            rvfi_ext_nmi       <= 1'b0;
            rvfi_ext_debug_req <= '0;
            rvfi_ext_mcycle    <= '0;
        end else begin
            rvfi_valid <= pop;
            if (pop) begin
                rvfi_order         <= order_q;
                rvfi_insn          <= head.insn;
                rvfi_trap          <= wb_trap;
                rvfi_halt          <= wb_halt;
                rvfi_intr          <= head.intr;
                rvfi_mode          <= head.mode;
                rvfi_rs1_addr      <= head.rs1_addr;
                rvfi_rs2_addr      <= head.rs2_addr;
                rvfi_rs1_rdata     <= head.rs1_rdata;
                rvfi_rs2_rdata     <= head.rs2_rdata;
                rvfi_rd_addr       <= eff_rd_addr;
                rvfi_rd_wdata      <= eff_rd_wdata;
                rvfi_pc_rdata      <= head.pc;
                rvfi_pc_wdata      <= wb_pc_wdata;
                rvfi_mem_addr      <= wb_mem_addr;
                rvfi_mem_rmask     <= eff_rmask;
                rvfi_mem_wmask     <= eff_wmask;
                rvfi_mem_rdata     <= (eff_rmask == 4'd0) ? 32'd0 : wb_mem_rdata;
                rvfi_mem_wdata     <= (eff_wmask == 4'd0) ? 32'd0 : wb_mem_wdata;
                rvfi_ext_mip       <= head.ext_mip;
                rvfi_ext_nmi       <= head.ext_nmi;
                rvfi_ext_debug_req <= head.ext_debug_req;
                rvfi_ext_mcycle    <= head.ext_mcycle;
            end
        end
    end

endmodule
